decoder_scan_ctrl: RTL and testbench
====================================

# decoder_scan_ctrl

Sequential address generator that drives the select and enable inputs of the `decoder4x16` stage (`a`, `b`, `c`, `d`, `en`). On a start pulse it walks a programmable run of addresses, modulo 16, up or down, and holds each address for a fixed dwell time. It then reports completion with a one-cycle `done` pulse. It sits directly upstream of `decoder4x16` and feeds its inputs one-to-one.

## Interface
- `DWELL`, default 4: clock cycles `en` is held high per address; legal range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `stop`  in  1  abort the current scan; sampled in DRIVE and BLANK.
- `dir`  in  1  0 = ascending, 1 = descending; latched on start.
- `start_addr`  in  4  first address; latched on start.
- `count`  in  5  number of addresses to visit, 1..16; 0 is treated as 16; latched on start.
- `a`  out  1  address bit 3 (MSB) to `decoder4x16`.
- `b`  out  1  address bit 2.
- `c`  out  1  address bit 1.
- `d`  out  1  address bit 0 (LSB).
- `en`  out  1  decoder enable.
- `busy`  out  1  high in DRIVE and BLANK.
- `done`  out  1  one-cycle pulse when a scan completes normally.

## Operation
- All outputs are registered. The reset value of every output is 0. Internal state resets to IDLE.
- **IDLE**: `en`=0, `{a,b,c,d}`=0.
  - On `start`=1, latch `dir`, `start_addr` and `count`.
  - Drive `{a,b,c,d}`=`start_addr`, `en`=1, `busy`=1, then enter DRIVE.
- **DRIVE**: address and `en`=1 are held for DWELL cycles by the dwell counter. At the end of the dwell:
  - Decrement the remaining count (5 bits).
  - If this was the last address, go to DONE.
  - Otherwise, step the address by +1 or −1 modulo 16 (15→0 ascending, 0→15 descending). Then enter BLANK, or stay in DRIVE when blanking is compiled out.
- **BLANK**: one cycle with `en`=0 and the next address already on `{a,b,c,d}`. Then enter DRIVE with `en`=1.
- **DONE**: one cycle with `en`=0, `busy`=0, `done`=1 and `{a,b,c,d}`=0. Then go to IDLE.
- **Boundary conditions**
  - `start` in DRIVE, BLANK or DONE is ignored.
  - `stop` in DRIVE or BLANK goes to IDLE on the next edge with all outputs 0 and no `done` pulse.
  - `stop` in IDLE or DONE is ignored.
  - `start` and `stop` high together in IDLE: `start` is taken.
  - A run with `count`=16 visits every address exactly once and does not revisit `start_addr`.
  - Reset asserted mid-scan forces all outputs to 0 immediately, without waiting for a clock edge. After reset deasserts, a new `start` is required.

## Timing
- `start` sampled at edge N: `en`=1, `busy`=1 and the address are valid after edge N, so latency is 1 edge.
- Scan length with blanking, from edge N to the `done` edge: count·DWELL + (count−1) cycles. `done` is high for exactly one cycle after that.
- Without blanking: count·DWELL cycles, then `done`. `en` stays continuously high while the address steps.
- The earliest next `start` is accepted in IDLE, one cycle after `done`.

## Configuration
- `DECODER_SCAN_BLANK_EN` defined: a BLANK cycle (`en`=0) is inserted between consecutive addresses to suppress decoder output glitches.
- `DECODER_SCAN_BLANK_EN` undefined: there is no BLANK state. The address changes on the edge that ends a dwell, and `en` stays high for the whole scan.

## Structure
- A shared package/header `decoder_scan_pkg` holds:
  - the state encodings IDLE, DRIVE, BLANK, DONE (2-bit);
  - the count width (5);
  - the address width (4).
- One sub-module, `scan_dwell_timer`:
  - loads DWELL−1 on load;
  - counts down;
  - asserts `expire` at 0.

## Test plan
- Ascending run with DWELL=4 and blanking on: `start_addr`=3, `count`=3, `dir`=0. Expect address 3, 4, 5, each with `en`=1 for 4 cycles, one `en`=0 cycle between addresses, then `done`=1 for 1 cycle. Total 14 cycles from start to `done`.
- Descending wrap: `start_addr`=1, `count`=3, `dir`=1. Expect addresses 1, 0, 15, then `done`.
- Full count: `count`=0 (treated as 16), `start_addr`=10, ascending. Expect 16 distinct addresses 10..15, 0..9, and `done` after 16·4+15 = 79 cycles.
- Stop mid-run: assert `stop` during the second address. The next edge gives `en`=0, `busy`=0 and address 0. No `done` pulse. `start` is accepted again on the following cycle.
- Ignored start: pulse `start` with new values while `busy`=1. Expect the original sequence to be unaffected.
- Async reset mid-DRIVE: deassert `rst_n` between clock edges. All outputs go to 0 immediately. After reset is released, outputs stay idle until `start`.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared types and widths for the decoder scan controller.
package decoder_scan_pkg;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Modulo-16 step; wrap falls out of the 4-bit arithmetic.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic              down);
    return down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Command and decoder-side signals of the scan controller, plus a state debug tap.
interface decoder_scan_ctrl_if;
  import decoder_scan_pkg::*;

  // Handshake: start is a single-cycle request with no ready; it is taken only
  // while the controller is in IDLE (busy=0 and done=0), otherwise dropped.
  logic              start;
  logic              stop;
  logic              dir;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  count;
  logic              a;
  logic              b;
  logic              c;
  logic              d;
  logic              en;
  logic              busy;
  logic              done;
  scan_state_t       state_dbg;

  modport master (
    output start, stop, dir, start_addr, count,
    input  a, b, c, d, en, busy, done, state_dbg
  );

  modport slave (
    input  start, stop, dir, start_addr, count,
    output a, b, c, d, en, busy, done, state_dbg
  );

endinterface

// File: rtl/scan_dwell_timer.sv
// Dwell down-counter: reloads DWELL-1 on load, counts down, flags expire at zero.
module scan_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam logic [7:0] RELOAD = 8'(DWELL - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expire = (cnt == 8'd0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Address scanner feeding decoder4x16; define DECODER_SCAN_BLANK_EN to insert an
// en=0 BLANK cycle between consecutive addresses.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input logic          clk,
    input logic          rst_n,
    decoder_scan_ctrl_if.slave bus
);

    scan_state_t       state;
    logic [ADDR_W-1:0] addr_q;
    logic              dir_q;
    logic [CNT_W-1:0]  rem_q;
    logic              en_q;
    logic              busy_q;
    logic              done_q;
    logic              expire;
    logic              load;

    // Reloading everywhere except mid-dwell keeps every DRIVE entry at a full DWELL.
    assign load = (state != DRIVE) || expire;

    scan_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            dir_q  <= 1'b0;
            rem_q  <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        dir_q  <= bus.dir;
                        rem_q  <= (bus.count == '0) ? CNT_W'(16) : bus.count;
                        addr_q <= bus.start_addr;
                        en_q   <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (bus.stop) begin
                        addr_q <= '0;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (expire) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            addr_q <= '0;
                            en_q   <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            addr_q <= step_addr(addr_q, dir_q);
`ifdef DECODER_SCAN_BLANK_EN
                            en_q   <= 1'b0;
                            state  <= BLANK;
`endif
                        end
                    end
                end
                BLANK: begin
                    if (bus.stop) begin
                        addr_q <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        en_q  <= 1'b1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a         = addr_q[3];
    assign bus.b         = addr_q[2];
    assign bus.c         = addr_q[1];
    assign bus.d         = addr_q[0];
    assign bus.en        = en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: scan table plus stop and async-reset sequences.
module tb_decoder_scan_ctrl;
    import decoder_scan_pkg::*;

    localparam int DWELL = 4;
`ifdef DECODER_SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decoder_scan_ctrl_if sif ();

    decoder_scan_ctrl #(.DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    typedef struct {
        logic       dir;
        logic [3:0] saddr;
        logic [4:0] cnt;
        int         inj_cyc;
        bit         inj_done;
        int         len_blank;
        int         len_plain;
        logic [3:0] last_addr;
        int         visits;
    } vec_t;

    vec_t       vecs[7];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [6:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // {done, busy, en, a, b, c, d}
    function automatic logic [6:0] obs();
        return {sif.done, sif.busy, sif.en, sif.a, sif.b, sif.c, sif.d};
    endfunction

    task automatic build_trace(input vec_t v);
        int         n;
        logic [3:0] ad;
        logic [3:0] nxt;
        n  = (v.cnt == 5'd0) ? 16 : int'(v.cnt);
        ad = v.saddr;
        for (int k = 0; k < n; k++) begin
            repeat (DWELL) exp_q.push_back({3'b011, ad});
            nxt = v.dir ? ad - 4'd1 : ad + 4'd1;
            if (BLANK_ON && k < n - 1) exp_q.push_back({3'b010, nxt});
            ad = nxt;
        end
        exp_q.push_back(7'b100_0000);
        exp_q.push_back(7'b000_0000);
    endtask

    task automatic run_vec(input int i);
        vec_t       v;
        int         cyc;
        int         done_idx;
        logic [15:0] mask;
        logic [3:0] last;
        logic [6:0] got;
        logic [6:0] e;
        v = vecs[i];
        cyc = 0;
        done_idx = 0;
        mask = '0;
        last = '0;
        build_trace(v);
        @(negedge clk);
        sif.dir = v.dir;
        sif.start_addr = v.saddr;
        sif.count = v.cnt;
        sif.start = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = exp_q.pop_front();
            got = obs();
            chk($sformatf("vec%0d_cyc%0d", i, cyc), 32'(got), 32'(e));
            if (got[6] && done_idx == 0) done_idx = cyc;
            if (got[4]) begin
                mask[got[3:0]] = 1'b1;
                last = got[3:0];
            end
            // Spurious start with different parameters while busy or in DONE.
            if (cyc == v.inj_cyc || (v.inj_done && got[6])) begin
                sif.start = 1'b1;
                sif.dir = ~v.dir;
                sif.start_addr = v.saddr + 4'd8;
                sif.count = 5'd1;
            end else begin
                sif.start = 1'b0;
            end
        end
        sif.start = 1'b0;
        chk($sformatf("vec%0d_len", i), 32'(done_idx - 1),
            32'(BLANK_ON ? v.len_blank : v.len_plain));
        chk($sformatf("vec%0d_last_addr", i), 32'(last), 32'(v.last_addr));
        chk($sformatf("vec%0d_visits", i), 32'($countones(mask)), 32'(v.visits));
    endtask

    task automatic stop_seq();
        @(negedge clk);
        sif.dir = 1'b0;
        sif.start_addr = 4'd3;
        sif.count = 5'd3;
        sif.start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            sif.start = 1'b0;
        end
        chk("stop_pre_second_addr", 32'(obs()), 32'({3'b011, 4'd4}));
        sif.stop = 1'b1;
        @(negedge clk);
        chk("stop_to_idle", 32'(obs()), 32'd0);
        // Restart with stop still high: start must win in IDLE.
        sif.start_addr = 4'd7;
        sif.count = 5'd2;
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        chk("restart_after_stop", 32'(obs()), 32'({3'b011, 4'd7}));
        @(negedge clk);
        chk("stop_held_in_drive", 32'(obs()), 32'd0);
        sif.stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_stop_idle%0d", k), 32'(obs()), 32'd0);
        end
    endtask

    task automatic reset_seq();
        @(negedge clk);
        sif.dir = 1'b1;
        sif.start_addr = 4'd2;
        sif.count = 5'd3;
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        @(negedge clk);
        chk("pre_reset_drive", 32'(obs()), 32'({3'b011, 4'd2}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(obs()), 32'd0);
        chk("async_reset_state", 32'(sif.state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_idle%0d", k), 32'(obs()), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 4'd3,  5'd3,  0, 1'b0, 14, 12, 4'd5,  3};
        vecs[1] = '{1'b1, 4'd1,  5'd3,  0, 1'b0, 14, 12, 4'd15, 3};
        vecs[2] = '{1'b0, 4'd10, 5'd0,  0, 1'b0, 79, 64, 4'd9,  16};
        vecs[3] = '{1'b1, 4'd15, 5'd1,  0, 1'b0, 4,  4,  4'd15, 1};
        vecs[4] = '{1'b1, 4'd0,  5'd16, 0, 1'b0, 79, 64, 4'd1,  16};
        vecs[5] = '{1'b0, 4'd14, 5'd4,  0, 1'b0, 19, 16, 4'd1,  4};
        vecs[6] = '{1'b0, 4'd5,  5'd2,  2, 1'b1, 9,  8,  4'd6,  2};

        rst_n = 1'b0;
        sif.start = 1'b0;
        sif.stop = 1'b0;
        sif.dir = 1'b0;
        sif.start_addr = '0;
        sif.count = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(obs()), 32'd0);
        chk("reset_state", 32'(sif.state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        sif.stop = 1'b1;
        @(negedge clk);
        chk("idle_stop_ignored", 32'(obs()), 32'd0);
        sif.stop = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(i);
        stop_seq();
        for (int i = 4; i < 6; i++) run_vec(i);
        reset_seq();
        run_vec(6);
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
